// File: rtl/chacha_qr_core.sv
// rtl/chacha_qr_core.sv - Multi-cycle ChaCha quarter-round engine, one ARX step per clock
module chacha_qr_core #(
  parameter int unsigned ROUNDS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out
);

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  round_q, round_d;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] a_d, b_d, c_d, d_d;
  logic        done_q, done_d;
  logic [31:0] sum, mix;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      round_q <= 8'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      c_q     <= 32'h0;
      d_q     <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    done_d  = 1'b0;
    sum     = 32'h0;
    mix     = 32'h0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = c_in;
          d_d     = d_in;
          step_d  = 2'd0;
          round_d = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        step_d = step_q + 2'd1;
        // add, xor with the fresh sum, then rotate: all within one edge
        case (step_q)
          2'd0: begin
            sum = a_q + b_q;
            mix = d_q ^ sum;
            a_d = sum;
            d_d = rotl(mix, 16);
          end
          2'd1: begin
            sum = c_q + d_q;
            mix = b_q ^ sum;
            c_d = sum;
            b_d = rotl(mix, 12);
          end
          2'd2: begin
            sum = a_q + b_q;
            mix = d_q ^ sum;
            a_d = sum;
            d_d = rotl(mix, 8);
          end
          default: begin
            sum = c_q + d_q;
            mix = b_q ^ sum;
            c_d = sum;
            b_d = rotl(mix, 7);
          end
        endcase
        if (step_q == 2'd3) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;
  assign d_out = d_q;

endmodule
